// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined IEEE-754 add/sub unit:
// rounding modes, exception flag bit positions and operand classes.
package fp_pkg;

   localparam logic [1:0] RM_RNE = 2'b00;
   localparam logic [1:0] RM_RTZ = 2'b01;
   localparam logic [1:0] RM_RDN = 2'b10;
   localparam logic [1:0] RM_RUP = 2'b11;

   localparam int FLAG_NX = 0;
   localparam int FLAG_UF = 1;
   localparam int FLAG_OF = 2;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_NV = 4;

   typedef enum logic [2:0] {
      CLS_ZERO,
      CLS_SUB,
      CLS_NORM,
      CLS_INF,
      CLS_QNAN,
      CLS_SNAN
   } fp_cls_e;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module fp_lzc #(
   parameter int WIDTH = 27,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] i_data,
   output logic [CW-1:0]    o_cnt
);

   always_comb begin
      o_cnt = CW'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (i_data[i]) o_cnt = CW'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/fp_add_pipe.sv
// 3-stage pipelined IEEE-754 adder/subtractor with valid/ready flow control.
// Define FP_ADD_DENORM_EN for subnormal support; otherwise subnormals flush to zero.
module fp_add_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int W     = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         sub,
   input  logic [1:0]   round_mode,
   input  logic         start,
   output logic         ready_out,
   output logic         valid_out,
   input  logic         ready_in,
   output logic [W-1:0] result,
   output logic [4:0]   flags
);

   localparam int FW = MAN_W + 4;
   localparam int SW = $clog2(FW + 1);
   localparam int XW = EXP_W + 2;
   localparam logic [EXP_W-1:0] EMAX = '1;
   localparam logic [EXP_W-1:0] EBIG = {{(EXP_W-1){1'b1}}, 1'b0};
   localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

   function automatic fp_cls_e classify(
      input logic [EXP_W-1:0] e,
      input logic [MAN_W-1:0] f
   );
      if (e == '0) return (f == '0) ? CLS_ZERO : CLS_SUB;
      if (e == EMAX) begin
         if (f == '0) return CLS_INF;
         return f[MAN_W-1] ? CLS_QNAN : CLS_SNAN;
      end
      return CLS_NORM;
   endfunction

   logic w_adv;
   assign w_adv     = !valid_out || ready_in;
   assign ready_out = w_adv;

   logic         r0_v, r0_sub;
   logic [W-1:0] r0_a, r0_b;
   logic [1:0]   r0_rm;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r0_v   <= 1'b0;
         r0_a   <= '0;
         r0_b   <= '0;
         r0_sub <= 1'b0;
         r0_rm  <= '0;
      end else if (w_adv) begin
         r0_v   <= start;
         r0_a   <= op_a;
         r0_b   <= op_b;
         r0_sub <= sub;
         r0_rm  <= round_mode;
      end
   end

   logic             w_sa, w_sb, w_swap, w_sbig, w_hbig, w_hsm;
   logic [EXP_W-1:0] w_ea, w_eb, w_ebig, w_esm, w_xbig, w_xsm, w_diff;
   logic [MAN_W-1:0] w_fa, w_fb, w_fbig, w_fsm;
   fp_cls_e          w_ca, w_cb;
   logic [SW-1:0]    w_sh;
   logic [FW-1:0]    w_mbig, w_msm0, w_msmr, w_msm;
   logic             w_lost, w_ainf, w_binf, w_nan, w_nv;

   always_comb begin
      w_sa = r0_a[W-1];
      w_sb = r0_b[W-1] ^ r0_sub;
      w_ea = r0_a[W-2:MAN_W];
      w_eb = r0_b[W-2:MAN_W];
      w_fa = r0_a[MAN_W-1:0];
      w_fb = r0_b[MAN_W-1:0];
`ifndef FP_ADD_DENORM_EN
      if (w_ea == '0) w_fa = '0;
      if (w_eb == '0) w_fb = '0;
`endif
      w_ca   = classify(w_ea, w_fa);
      w_cb   = classify(w_eb, w_fb);
      w_swap = {w_eb, w_fb} > {w_ea, w_fa};
      w_sbig = w_swap ? w_sb : w_sa;
      w_ebig = w_swap ? w_eb : w_ea;
      w_fbig = w_swap ? w_fb : w_fa;
      w_esm  = w_swap ? w_ea : w_eb;
      w_fsm  = w_swap ? w_fa : w_fb;
      // Subnormals and zeros align as exponent 1 with no hidden bit
      w_hbig = w_ebig != '0;
      w_hsm  = w_esm != '0;
      w_xbig = w_hbig ? w_ebig : EXP_W'(1);
      w_xsm  = w_hsm ? w_esm : EXP_W'(1);
      w_diff = w_xbig - w_xsm;
      if (32'(w_diff) > 32'(FW - 1)) w_sh = SW'(FW - 1);
      else w_sh = SW'(w_diff);
      w_mbig = {w_hbig, w_fbig, 3'b000};
      w_msm0 = {w_hsm, w_fsm, 3'b000};
      w_msmr = w_msm0 >> w_sh;
      w_lost = |(w_msm0 & ~({FW{1'b1}} << w_sh));
      w_msm  = {w_msmr[FW-1:1], w_msmr[0] | w_lost};
      w_ainf = w_ca == CLS_INF;
      w_binf = w_cb == CLS_INF;
      w_nan  = (w_ca == CLS_QNAN) || (w_ca == CLS_SNAN) ||
               (w_cb == CLS_QNAN) || (w_cb == CLS_SNAN) ||
               (w_ainf && w_binf && (w_sa != w_sb));
      w_nv   = (w_ca == CLS_SNAN) || (w_cb == CLS_SNAN) ||
               (w_ainf && w_binf && (w_sa != w_sb));
   end

   logic             r1_v, r1_s, r1_esub, r1_nan, r1_nv, r1_inf, r1_infs;
   logic [EXP_W-1:0] r1_e;
   logic [FW-1:0]    r1_mb, r1_ms;
   logic [1:0]       r1_rm;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_v    <= 1'b0;
         r1_s    <= 1'b0;
         r1_esub <= 1'b0;
         r1_e    <= '0;
         r1_mb   <= '0;
         r1_ms   <= '0;
         r1_nan  <= 1'b0;
         r1_nv   <= 1'b0;
         r1_inf  <= 1'b0;
         r1_infs <= 1'b0;
         r1_rm   <= '0;
      end else if (w_adv) begin
         r1_v    <= r0_v;
         r1_s    <= w_sbig;
         r1_esub <= w_sa ^ w_sb;
         r1_e    <= w_xbig;
         r1_mb   <= w_mbig;
         r1_ms   <= w_msm;
         r1_nan  <= w_nan;
         r1_nv   <= w_nv;
         r1_inf  <= w_ainf || w_binf;
         r1_infs <= w_ainf ? w_sa : w_sb;
         r1_rm   <= r0_rm;
      end
   end

   logic [FW:0]   w_sum;
   logic [SW-1:0] w_lz, w_lsh;
   logic [FW-1:0] w_nm;
   logic [XW-1:0] w_ne;
   logic          w_flush;

   assign w_sum = r1_esub ? ({1'b0, r1_mb} - {1'b0, r1_ms})
                          : ({1'b0, r1_mb} + {1'b0, r1_ms});

   fp_lzc #(.WIDTH(FW), .CW(SW)) u_lzc (
      .i_data (w_sum[FW-1:0]),
      .o_cnt  (w_lz)
   );

   always_comb begin
      w_lsh   = w_lz;
      w_flush = 1'b0;
`ifdef FP_ADD_DENORM_EN
      if (32'(w_lz) > 32'(r1_e) - 32'd1) w_lsh = SW'(r1_e - EXP_W'(1));
`else
      w_flush = !w_sum[FW] && (w_sum[FW-1:0] != '0) &&
                (32'(w_lz) >= 32'(r1_e));
`endif
      w_nm = w_sum[FW-1:0] << w_lsh;
      w_ne = XW'(r1_e) - XW'(w_lsh);
      if (!w_nm[FW-1]) w_ne = '0;
      if (w_sum[FW]) begin
         w_nm = {w_sum[FW:2], |w_sum[1:0]};
         w_ne = XW'(r1_e) + XW'(1);
      end
   end

   logic          r2_v, r2_s, r2_esub, r2_nan, r2_nv, r2_inf, r2_infs;
   logic          r2_flush;
   logic [XW-1:0] r2_e;
   logic [FW-1:0] r2_m;
   logic [1:0]    r2_rm;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r2_v     <= 1'b0;
         r2_s     <= 1'b0;
         r2_esub  <= 1'b0;
         r2_e     <= '0;
         r2_m     <= '0;
         r2_flush <= 1'b0;
         r2_nan   <= 1'b0;
         r2_nv    <= 1'b0;
         r2_inf   <= 1'b0;
         r2_infs  <= 1'b0;
         r2_rm    <= '0;
      end else if (w_adv) begin
         r2_v     <= r1_v;
         r2_s     <= r1_s;
         r2_esub  <= r1_esub;
         r2_e     <= w_ne;
         r2_m     <= w_nm;
         r2_flush <= w_flush;
         r2_nan   <= r1_nan;
         r2_nv    <= r1_nv;
         r2_inf   <= r1_inf;
         r2_infs  <= r1_infs;
         r2_rm    <= r1_rm;
      end
   end

   logic [MAN_W:0]   w_keep;
   logic [MAN_W+1:0] w_kr;
   logic [MAN_W-1:0] w_rf;
   logic [XW-1:0]    w_re;
   logic             w_nx, w_inc, w_of, w_oinf, w_zs;
   logic [W-1:0]     w_res;
   logic [4:0]       w_flg;

   always_comb begin
      w_keep = r2_m[FW-1:3];
      w_nx   = |r2_m[2:0];
      w_inc  = 1'b0;
      w_oinf = 1'b1;
      unique case (r2_rm)
         RM_RNE: w_inc = r2_m[2] && (r2_m[1] || r2_m[0] || w_keep[0]);
         RM_RTZ: w_oinf = 1'b0;
         RM_RDN: begin
            w_inc  = w_nx && r2_s;
            w_oinf = r2_s;
         end
         RM_RUP: begin
            w_inc  = w_nx && !r2_s;
            w_oinf = !r2_s;
         end
      endcase
      w_kr = {1'b0, w_keep} + {{(MAN_W+1){1'b0}}, w_inc};
      w_rf = w_kr[MAN_W+1] ? '0 : w_kr[MAN_W-1:0];
      // A subnormal that rounds up into the hidden bit becomes exponent 1
      if (w_kr[MAN_W+1]) w_re = r2_e + XW'(1);
      else if ((r2_e == '0) && w_kr[MAN_W]) w_re = XW'(1);
      else w_re = r2_e;
      w_of = w_re >= XW'(EMAX);
      w_zs = r2_esub ? (r2_rm == RM_RDN) : r2_s;
      w_res = '0;
      w_flg = '0;
      if (r2_nan) begin
         w_res = QNAN;
         w_flg[FLAG_NV] = r2_nv;
      end else if (r2_inf) begin
         w_res = {r2_infs, EMAX, {MAN_W{1'b0}}};
      end else if (r2_flush) begin
         w_res = {r2_s, {(W-1){1'b0}}};
         w_flg[FLAG_UF] = 1'b1;
         w_flg[FLAG_NX] = 1'b1;
      end else if (w_of) begin
         w_res = w_oinf ? {r2_s, EMAX, {MAN_W{1'b0}}}
                        : {r2_s, EBIG, {MAN_W{1'b1}}};
         w_flg[FLAG_OF] = 1'b1;
         w_flg[FLAG_NX] = 1'b1;
      end else if (r2_m == '0) begin
         w_res = {w_zs, {(W-1){1'b0}}};
      end else begin
         w_res = {r2_s, w_re[EXP_W-1:0], w_rf};
         w_flg[FLAG_NX] = w_nx;
         w_flg[FLAG_UF] = w_nx && (r2_e == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_out <= 1'b0;
         result    <= '0;
         flags     <= '0;
      end else if (w_adv) begin
         valid_out <= r2_v;
         if (r2_v) begin
            result <= w_res;
            flags  <= w_flg;
         end
      end
   end

endmodule
